// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between instruction and data requesters; CACHELINE_ARBITER_ROUND_ROBIN_EN alternates contended grants.
// Latency: grant edge + memory latency + one RESP cycle; requesters hold requests until their resp pulse.
module cacheline_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_read,
    input  logic              i_write,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    input  logic              d_read,
    input  logic              d_write,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              i_req, d_req, pick;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

`ifdef CACHELINE_ARBITER_ROUND_ROBIN_EN
    // On contention, hand the port to whichever side did not win last time.
    assign pick = i_req ? (d_req ? ~last_grant_q : SIDE_I) : SIDE_D;
`else
    assign pick = i_req ? SIDE_I : SIDE_D;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= SIDE_I;
            last_grant_q <= SIDE_D;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        pmem_addr    = '0;
        pmem_wdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    if (pick == SIDE_D) begin
                        wr_d    = d_write;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        state_d = D_BUSY;
                    end else begin
                        wr_d    = i_write;
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        state_d = I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                pmem_read  = ~wr_q;
                pmem_write = wr_q;
                if (pmem_resp) begin
                    // A write echoes its own line back to the requester.
                    line_d  = wr_q ? wdata_q : pmem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (grant_q == SIDE_D) begin
                    d_resp  = 1'b1;
                    d_rdata = line_q;
                end else begin
                    i_resp  = 1'b1;
                    i_rdata = line_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, 32, address width; LINE_W, 256, cacheline width.
REQ-002 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- i_addr  in  ADDR_W  instruction-side line address
- i_wdata  in  LINE_W  instruction-side write line
- i_read, i_write  in  1 each  instruction-side requests, held until i_resp
- i_rdata  out  LINE_W  instruction-side read line
- i_resp  out  1  instruction-side completion pulse
- d_addr, d_wdata, d_read, d_write, d_rdata, d_resp: data-side equivalents of the i_* ports
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_read, pmem_write  out  1 each  memory requests
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion

Function
REQ-004 The FSM SHALL have states IDLE, I_BUSY, D_BUSY and RESP.
REQ-005 In IDLE, a side is requesting when its read or write is high. If no side requests, the FSM SHALL stay in IDLE. Otherwise it SHALL grant one side, latch that side's addr, wdata and op into registers, and go to I_BUSY or D_BUSY at the next edge.
REQ-006 If a side drives read and write high together, the latched op SHALL be write.
REQ-007 In I_BUSY/D_BUSY, pmem_addr, pmem_wdata, pmem_read and pmem_write SHALL come only from the latched registers. Requester input changes SHALL have no effect on the memory port.
REQ-008 In I_BUSY/D_BUSY, exactly one of pmem_read or pmem_write SHALL be high every cycle until pmem_resp is sampled high.
REQ-009 On the edge where pmem_resp is high, the FSM SHALL capture pmem_rdata into a line register and go to RESP.
REQ-010 In RESP, the FSM SHALL drive i_resp or d_resp high for exactly one cycle, selected by the latched grant, and then return to IDLE.
REQ-011 In RESP, the granted side's rdata SHALL equal the captured line. For a write, it SHALL equal the latched wdata.
REQ-012 In RESP, pmem_read and pmem_write SHALL be low.
REQ-013 In RESP, requests SHALL NOT be arbitrated. Re-arbitration SHALL happen only in IDLE.
REQ-014 Requester latency from request to resp SHALL be: memory latency + 2 cycles (grant edge + RESP cycle) when uncontended.
REQ-015 i_rdata and d_rdata SHALL be '0 outside their side's RESP cycle. The non-granted side's resp SHALL never be asserted.
REQ-016 pmem_resp sampled in IDLE or RESP SHALL be ignored.
REQ-017 A request dropped before grant SHALL be forgotten. A request dropped after grant SHALL still complete.
REQ-018 A last_grant register SHALL record the side granted at every grant.

Reset
REQ-019 While rst is sampled high, the FSM SHALL enter IDLE, all latch registers SHALL clear to 0, and last_grant SHALL be set to DATA.
REQ-020 In the cycle after reset, all outputs SHALL be 0.
REQ-021 Reset mid-transaction SHALL abandon the pmem access. No resp SHALL be issued for it.

Configuration
REQ-022 The feature macro SHALL be CACHELINE_ARBITER_ROUND_ROBIN_EN.
REQ-023 With CACHELINE_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL grant the side not equal to last_grant, so the first contended grant after reset goes to INSTR.
REQ-024 Without CACHELINE_ARBITER_ROUND_ROBIN_EN, simultaneous requests SHALL always grant INSTR. last_grant SHALL still be maintained but unused.

Verification
REQ-025 Read: i_read=1, i_addr=0x00000040, memory returns 0xAA..AA after 3 cycles -> pmem_read high 3 cycles with addr 0x40, i_resp pulses once with i_rdata=0xAA..AA, d_resp never high.
REQ-026 Write: d_write=1, d_addr=0x00001000, d_wdata=0x55..55 -> pmem_write high with pmem_wdata=0x55..55 until pmem_resp, then d_resp one-cycle pulse.
REQ-027 Contention: i_read and d_read high together in IDLE, each held until resp, RR undefined -> instruction serviced first, then data after one IDLE cycle. Same stimulus with RR defined, repeated three times -> grants I, D, I, D, I, D.
REQ-028 Latch stability: d_addr changed from 0x100 to 0x200 during D_BUSY -> pmem_addr stays 0x100 throughout.
REQ-029 Reset mid-op: rst pulsed during I_BUSY -> next cycle all outputs 0, state IDLE, no i_resp ever for that request.
REQ-030 Spurious response: pmem_resp=1 while in IDLE with no request -> no resp on either side, state remains IDLE.
